// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB initiator that drains a small command FIFO into
// APB SETUP/ACCESS transfers and reports each completion on a one-cycle
// response strobe. Targets the CORDIC accelerator register space.
//
// Optional feature: define APB_PREADY_EN to add a PREADY input that lets
// the slave insert wait states. Without it, ACCESS lasts exactly one
// cycle, which suits a zero-wait-state slave.

module apb_cmd_master #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
`ifdef APB_PREADY_EN
  input  logic              PREADY,
`endif
  input  logic [DATA_W-1:0] PRDATA
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Command FIFO storage; contents need no reset because the count gates use
  logic              r_fifoWrite [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifoAddr  [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifoData  [FIFO_DEPTH];

  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;

  state_t            r_state;
  state_t            w_nextState;

  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rspValid;
  logic              r_rspWrite;
  logic [DATA_W-1:0] r_rspRdata;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_slaveReady;
  logic              w_complete;

  // The full flag alone decides acceptance: a pop in the same cycle does not
  // open a slot, which keeps req_ready a pure function of registered state.
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign req_ready = !w_full;
  assign w_push    = req_valid && !w_full;

`ifdef APB_PREADY_EN
  assign w_slaveReady = PREADY;
`else
  assign w_slaveReady = 1'b1;
`endif

  // A transfer finishes at the edge that ends an ACCESS cycle the slave accepts
  assign w_complete = (r_state == ACCESS) && w_slaveReady;

  // Next-state decode; pops happen only on entry to SETUP
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nextState = SETUP;
        end
      end
      SETUP: begin
        w_nextState = ACCESS;
      end
      ACCESS: begin
        if (w_complete) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_nextState = SETUP;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Write accepted commands into the FIFO slot at the write pointer
  always_ff @(posedge PCLK) begin
    if (w_push) begin
      r_fifoWrite[r_wrPtr] <= req_write;
      r_fifoAddr[r_wrPtr]  <= req_addr;
      r_fifoData[r_wrPtr]  <= req_wdata;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // State register plus registered APB control, driven from the next state
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_psel    <= (w_nextState != IDLE);
      r_penable <= (w_nextState == ACCESS);
    end
  end

  // Address/direction/data load on each pop and otherwise hold their last value
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_pop) begin
      r_pwrite <= r_fifoWrite[r_rdPtr];
      r_paddr  <= r_fifoAddr[r_rdPtr];
      r_pwdata <= r_fifoData[r_rdPtr];
    end
  end

  // Response strobe for every completed transfer; read data holds until the next one
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rspValid <= 1'b0;
      r_rspWrite <= 1'b0;
      r_rspRdata <= '0;
    end else begin
      r_rspValid <= w_complete;
      if (w_complete) begin
        r_rspWrite <= r_pwrite;
        r_rspRdata <= r_pwrite ? '0 : PRDATA;
      end
    end
  end

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rspValid;
  assign rsp_write = r_rspWrite;
  assign rsp_rdata = r_rspRdata;
  assign busy      = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: scoreboard bench for apb_cmd_master with a simple
// memory-backed APB slave. Builds with or without APB_PREADY_EN.

module tb_apb_cmd_master;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  wire               slaveReady;

  logic              randomReady = 1'b0;
  logic              randBit     = 1'b1;
  logic              forcedReady = 1'b1;

  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_t;

  rsp_t              expRsp [$];
  bus_t              expBus [$];
  logic [DATA_W-1:0] refMem [64];
  logic [DATA_W-1:0] slaveMem [64];
  logic [63:0]       slaveWritten = '0;

  int nCompared   = 0;
  int nMismatched = 0;
  int rspSeen     = 0;

  always #5 PCLK = ~PCLK;

  apb_cmd_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .busy(busy),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
`ifdef APB_PREADY_EN
    .PREADY(slaveReady),
`endif
    .PRDATA(PRDATA)
  );

  // Power-on contents of the slave register space
  function automatic logic [DATA_W-1:0] baseWord(input logic [ADDR_W-1:0] a);
    case (a)
      6'h14:   baseWord = 32'h0000B505;
      6'h18:   baseWord = 32'hDEADBEEF;
      default: baseWord = 32'hC0DE0000 | {26'd0, a};
    endcase
  endfunction

  assign PRDATA     = slaveWritten[PADDR] ? slaveMem[PADDR] : baseWord(PADDR);
  assign slaveReady = randomReady ? randBit : forcedReady;

  // Slave register writes land at the completing edge of a write transfer
  always @(posedge PCLK) begin
    if (PRESETn && PSEL && PENABLE && PWRITE && slaveReady) begin
      slaveMem[PADDR]     <= PWDATA;
      slaveWritten[PADDR] <= 1'b1;
    end
  end

  // Random wait-state source, only used when randomReady is set
  initial begin
    forever begin
      @(posedge PCLK);
      #1 randBit = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one command until it is accepted; the model learns it at the push edge
  task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, output int stalls);
    bit accepted;
    rsp_t r;
    bus_t b;
    accepted  = 0;
    stalls    = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge PCLK);
      if (req_ready) accepted = 1;
      else stalls++;
      @(posedge PCLK);
      #1;
    end
    req_valid = 1'b0;
    if (accepted) begin
      r.write = wr;
      r.rdata = wr ? '0 : refMem[addr];
      b.write = wr;
      b.addr  = addr;
      b.wdata = data;
      expRsp.push_back(r);
      expBus.push_back(b);
      if (wr) refMem[addr] = data;
    end else begin
      checkOutput("accept timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic waitIdle(input string name);
    bit idle;
    idle = 0;
    for (int c = 0; c < 600 && !idle; c++) begin
      @(negedge PCLK);
      if (!busy) idle = 1;
    end
    checkOutput(name, idle, 1);
  endtask

  task automatic waitAccess(output bit found);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) found = 1;
    end
    checkOutput("ACCESS reached", found, 1);
  endtask

  // Scoreboard monitor: every response and every accepted ACCESS is matched in order
  initial begin
    rsp_t er;
    bus_t eb;
    forever begin
      @(negedge PCLK);
      if (PRESETn) begin
        if (rsp_valid) begin
          rspSeen++;
          if (expRsp.size() == 0) begin
            checkOutput("unexpected rsp_valid", 64'd1, 64'd0);
          end else begin
            er = expRsp.pop_front();
            checkOutput("rsp_write", rsp_write, er.write);
            checkOutput("rsp_rdata", rsp_rdata, er.rdata);
          end
        end
        if (PENABLE) checkOutput("PENABLE without PSEL", PSEL, 1);
        if (PSEL && PENABLE && slaveReady) begin
          if (expBus.size() == 0) begin
            checkOutput("unexpected transfer", 64'd1, 64'd0);
          end else begin
            eb = expBus.pop_front();
            checkOutput("PADDR order", PADDR, eb.addr);
            checkOutput("PWRITE order", PWRITE, eb.write);
            if (eb.write) checkOutput("PWDATA order", PWDATA, eb.wdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int st;
    int totalStalls;
    int rspBefore;
    bit found;
    logic wr;
    logic [ADDR_W-1:0] ad;

    for (int i = 0; i < 64; i++) refMem[i] = baseWord(ADDR_W'(i));
    PRESETn   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("reset PSEL", PSEL, 0);
    checkOutput("reset PENABLE", PENABLE, 0);
    checkOutput("reset PWRITE", PWRITE, 0);
    checkOutput("reset rsp_valid", rsp_valid, 0);
    checkOutput("reset rsp_write", rsp_write, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset PADDR", PADDR, 0);
    checkOutput("reset PWDATA", PWDATA, 0);
    checkOutput("reset rsp_rdata", rsp_rdata, 0);
    checkOutput("reset req_ready", req_ready, 1);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;

    // Single write: exact cycle-level shape and latency
    applyStimulus(1'b1, 6'h00, 32'h00000007, st);
    @(negedge PCLK);
    checkOutput("wr idle PSEL", PSEL, 0);
    checkOutput("wr queued busy", busy, 1);
    @(negedge PCLK);
    checkOutput("wr setup PSEL", PSEL, 1);
    checkOutput("wr setup PENABLE", PENABLE, 0);
    checkOutput("wr setup PADDR", PADDR, 6'h00);
    checkOutput("wr setup PWRITE", PWRITE, 1);
    checkOutput("wr setup PWDATA", PWDATA, 32'h7);
    @(negedge PCLK);
    checkOutput("wr access PSEL", PSEL, 1);
    checkOutput("wr access PENABLE", PENABLE, 1);
    checkOutput("wr access PWDATA", PWDATA, 32'h7);
    @(negedge PCLK);
    checkOutput("wr rsp_valid", rsp_valid, 1);
    checkOutput("wr rsp_write", rsp_write, 1);
    checkOutput("wr done PSEL", PSEL, 0);
    checkOutput("wr done busy", busy, 0);
    @(negedge PCLK);
    checkOutput("wr rsp pulse width", rsp_valid, 0);
    checkOutput("wr PWDATA holds", PWDATA, 32'h7);

    // Single read of 0x14
    @(posedge PCLK);
    #1;
    applyStimulus(1'b0, 6'h14, $urandom, st);
    repeat (2) @(negedge PCLK);
    checkOutput("rd setup PWRITE", PWRITE, 0);
    checkOutput("rd setup PADDR", PADDR, 6'h14);
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge PCLK);
      if (rsp_valid) found = 1;
    end
    checkOutput("rd rsp seen", found, 1);
    checkOutput("rd rsp_rdata", rsp_rdata, 32'h0000B505);
    checkOutput("rd rsp_write", rsp_write, 0);
    @(negedge PCLK);
    checkOutput("rd rsp_rdata holds", rsp_rdata, 32'h0000B505);

    // Four back-to-back writes: PSEL held for 8 cycles with PENABLE alternating
    @(posedge PCLK);
    #1;
    rspBefore = rspSeen;
    fork
      begin
        applyStimulus(1'b1, 6'h04, $urandom, st);
        applyStimulus(1'b1, 6'h08, $urandom, st);
        applyStimulus(1'b1, 6'h0C, $urandom, st);
        applyStimulus(1'b1, 6'h10, $urandom, st);
      end
      begin
        bit rose;
        rose = 0;
        for (int c = 0; c < 20 && !rose; c++) begin
          @(negedge PCLK);
          if (PSEL) rose = 1;
        end
        checkOutput("b2b PSEL rise", rose, 1);
        for (int i = 0; i < 8; i++) begin
          if (i > 0) @(negedge PCLK);
          checkOutput("b2b PSEL held", PSEL, 1);
          checkOutput("b2b PENABLE phase", PENABLE, 64'(i % 2));
        end
        @(negedge PCLK);
        checkOutput("b2b last rsp", rsp_valid, 1);
        checkOutput("b2b PSEL drop", PSEL, 0);
        checkOutput("b2b busy drop", busy, 0);
      end
    join
    @(negedge PCLK);
    checkOutput("b2b rsp count", 64'(rspSeen - rspBefore), 64'd4);

    // Eight consecutive commands overrun the 4-entry FIFO by exactly one cycle
    @(posedge PCLK);
    #1;
    totalStalls = 0;
    for (int i = 0; i < 8; i++) begin
      wr = 1'($urandom_range(0, 1));
      ad = ADDR_W'($urandom_range(0, 63));
      applyStimulus(wr, ad, $urandom, st);
      totalStalls += st;
    end
    checkOutput("full stall cycles", 64'(totalStalls), 64'd1);
    waitIdle("full drain");

    // Reset during ACCESS of a read aborts silently
    @(posedge PCLK);
    #1;
    applyStimulus(1'b0, 6'h20, $urandom, st);
    waitAccess(found);
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("abort PSEL", PSEL, 0);
    checkOutput("abort PENABLE", PENABLE, 0);
    expRsp.delete();
    expBus.delete();
    rspBefore = rspSeen;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (4) @(negedge PCLK);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort req_ready", req_ready, 1);
    checkOutput("abort no rsp", 64'(rspSeen - rspBefore), 64'd0);
    checkOutput("abort PSEL idle", PSEL, 0);

`ifdef APB_PREADY_EN
    // Three wait states on a read of 0x18
    @(posedge PCLK);
    #1;
    forcedReady = 1'b0;
    applyStimulus(1'b0, 6'h18, $urandom, st);
    waitAccess(found);
    checkOutput("wait PADDR 1", PADDR, 6'h18);
    for (int i = 2; i <= 3; i++) begin
      @(negedge PCLK);
      checkOutput("wait PENABLE held", PENABLE, 1);
      checkOutput("wait PADDR stable", PADDR, 6'h18);
      checkOutput("wait no rsp", rsp_valid, 0);
    end
    @(posedge PCLK);
    #1 forcedReady = 1'b1;
    @(negedge PCLK);
    checkOutput("wait 4th PENABLE", PENABLE, 1);
    checkOutput("wait 4th PADDR", PADDR, 6'h18);
    @(negedge PCLK);
    checkOutput("wait rsp_valid", rsp_valid, 1);
    checkOutput("wait rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    randomReady = 1'b1;
`endif

    // Random traffic against the reference model
    @(posedge PCLK);
    #1;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      ad = ADDR_W'($urandom_range(0, 63));
      applyStimulus(wr, ad, $urandom, st);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge PCLK);
        #1;
      end
    end
    waitIdle("random drain");
    repeat (2) @(negedge PCLK);
    checkOutput("rsp queue empty", 64'(expRsp.size()), 64'd0);
    checkOutput("bus queue empty", 64'(expBus.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
